// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: request/acknowledge port between the memory stage and data memory.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage driving a variable-latency data memory, stalling until done.
// Optional MEM_MISALIGN_CHECK_EN rejects accesses with ALU_out[1:0]!=0 without touching memory.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          MEM,
  input  logic [1:0]          WB,
  input  logic [31:0]         ALU_out,
  input  logic [31:0]         write_data,
  input  logic [4:0]          writeReg,
  mem_access_stage_if.master  mem,
  output logic                stall,
  output logic [1:0]          WB_o,
  output logic [31:0]         DM_out,
  output logic [31:0]         ALU_out_o,
  output logic [4:0]          writeReg_o,
  output logic                bus_err,
  output logic                misalign
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_cur, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_rdata;
  logic r_err, r_mis;
  logic w_op, w_mis, w_timeout;
  assign w_op = MEM[1] | MEM[0];
`ifdef MEM_MISALIGN_CHECK_EN
  assign w_mis = w_op & (|ALU_out[1:0]);
`else
  assign w_mis = 1'b0;
`endif
  assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
  // reset forces the IDLE view so stall tracks op while rst is held
  assign w_cur = rst ? IDLE : r_state;
  assign ALU_out_o = ALU_out;
  assign writeReg_o = writeReg;
  always_comb begin
    w_next = w_cur;
    stall = 1'b0;
    WB_o = WB;
    DM_out = '0;
    bus_err = 1'b0;
    misalign = 1'b0;
    case (w_cur)
      IDLE: begin
        stall = w_op;
        WB_o = w_op ? 2'b00 : WB;
        w_next = w_mis ? DONE : w_op ? WAIT : IDLE;
      end
      WAIT: begin
        stall = 1'b1;
        WB_o = 2'b00;
        w_next = (mem.mem_ack || w_timeout) ? DONE : WAIT;
      end
      DONE: begin
        DM_out = r_rdata;
        WB_o = (r_err || r_mis) ? 2'b00 : WB;
        bus_err = r_err;
        misalign = r_mis;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      mem.mem_req <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
      r_cnt <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
      r_mis <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_mis) begin
            r_rdata <= '0;
            r_mis <= 1'b1;
          end else if (w_op) begin
            mem.mem_addr <= ALU_out;
            mem.mem_wdata <= write_data;
            mem.mem_we <= MEM[0];
            mem.mem_req <= 1'b1;
            r_cnt <= '0;
          end
        end
        WAIT: begin
          // an ack arriving on the timeout cycle still completes the access
          if (mem.mem_ack) begin
            r_rdata <= mem.mem_we ? 32'h0 : mem.mem_rdata;
            mem.mem_req <= 1'b0;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            mem.mem_req <= 1'b0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_err <= 1'b0;
          r_mis <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns the MemRead/MemWrite controls from EX/MEM into a request/acknowledge transaction on a variable-latency data-memory port. It freezes upstream stages with `stall` until the transaction completes.
- Presents WB controls, `DM_out`, `ALU_out` and `writeReg` to MEM/WB.
- While stalled, drives a bubble into MEM/WB so nothing writes back twice.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT before the access is abandoned (range 2..255).
- CW, 8, width of the wait counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- MEM  in  2  from EX/MEM: [1]=MemRead, [0]=MemWrite
- WB  in  2  WB controls from EX/MEM
- ALU_out  in  32  address / ALU result from EX/MEM
- write_data  in  32  store data from EX/MEM
- writeReg  in  5  destination register from EX/MEM
- mem_req  out  1  memory request, registered
- mem_we  out  1  1=write, registered
- mem_addr  out  32  word address, registered
- mem_wdata  out  32  store data, registered
- mem_ack  in  1  memory completion, valid only while mem_req=1
- mem_rdata  in  32  read data, valid with mem_ack
- stall  out  1  freeze PC/IF-ID/ID-EX/EX-MEM
- WB_o  out  2  to MEM/WB
- DM_out  out  32  to MEM/WB
- ALU_out_o  out  32  to MEM/WB (ALU_out passthrough)
- writeReg_o  out  5  to MEM/WB (writeReg passthrough)
- bus_err  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse, see Optional Feature

Behaviour:
- Definitions:
  - op = MEM[1] | MEM[0].
  - is_wr = MEM[0]. MemRead and MemWrite both set is treated as a write.
- FSM states IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - op=0: stall=0. WB_o=WB, DM_out=0, ALU_out_o/writeReg_o pass through. Stay IDLE. Zero added latency.
  - op=1: stall=1, WB_o=0 (bubble). Next state WAIT.
  - Capture on that edge: mem_addr<=ALU_out, mem_wdata<=write_data, mem_we<=is_wr, mem_req<=1, counter<=0.
- WAIT:
  - stall=1, WB_o=0. mem_req, mem_we, mem_addr, mem_wdata are held stable.
  - mem_ack=1: rdata_q<=mem_rdata for reads, 0 for writes. mem_req<=0. Next state DONE, err_q<=0.
  - Else counter increments. When counter==TIMEOUT-1 without ack: mem_req<=0, rdata_q<=0, err_q<=1, next state DONE.
- DONE:
  - stall=0, DM_out=rdata_q. ALU_out_o/writeReg_o pass through (EX/MEM is still frozen from the previous cycle).
  - WB_o=WB if err_q=0, else WB_o=0 (cancelled writeback). bus_err=err_q.
  - Next state is always IDLE. EX/MEM advances on this edge.
- Minimum memory-op latency: 3 cycles (IDLE, WAIT with ack, DONE). stall is high for exactly 2+N cycles, where N is the number of wait cycles before ack.
- Back-to-back memory ops: the new op is seen in IDLE on the cycle after DONE, with no lost or duplicated access.
- mem_ack in IDLE or DONE is ignored. mem_rdata is sampled only on the acknowledged cycle.
- Ack on the timeout cycle: the ack wins and err_q=0.
- Reset (synchronous, any state, including mid-WAIT): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, rdata_q=0, err_q=0.
  - With rst=1 held, combinational outputs evaluate as IDLE: stall follows op, bus_err=0, misalign=0.
- No arithmetic on the data path. mem_addr is ALU_out unmodified.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, an op with ALU_out[1:0]!=0 issues no request.
  - IDLE goes straight to DONE with rdata_q=0 and a flag set. In DONE: misalign=1, WB_o=0, stall=0.
  - Total stall is 1 cycle.
- Undefined: no alignment check; misalign is tied 0.

Test Plan:
- rst high 2 cycles mid-WAIT (mem_req=1) -> next cycle mem_req=0, stall=0 for op=0, bus_err=0, DM_out=0.
- R-type (MEM=00, WB=2'b10, ALU_out=32'h0000_0040, writeReg=5) -> same cycle stall=0, WB_o=10, ALU_out_o=32'h40, DM_out=0, mem_req never rises.
- lw (MEM=10, ALU_out=32'h100), mem_ack after 3 wait cycles with mem_rdata=32'hCAFE_F00D:
  - mem_addr=32'h100, mem_we=0.
  - stall high 5 cycles, WB_o=0 throughout.
  - DONE cycle: DM_out=32'hCAFE_F00D, WB_o=WB.
- sw (MEM=01, ALU_out=32'h200, write_data=32'h1234_5678), immediate ack:
  - mem_we=1, mem_wdata=32'h1234_5678 stable until ack.
  - stall 2 cycles, DM_out=0.
- lw with no ack, TIMEOUT=16:
  - mem_req drops after 16 WAIT cycles.
  - DONE cycle: bus_err=1 for one cycle, WB_o=0, DM_out=0.
  - Back-to-back lw follows and is served normally.
- MEM_MISALIGN_CHECK_EN, lw at ALU_out=32'h103 -> no mem_req, misalign=1 for one cycle, WB_o=0, stall 1 cycle. Without the macro: normal access to 32'h103.
